// File: rtl/cd_cfg_arbiter_pkg.sv
// Shared constants, FSM state type and address legality / data masking helper
// for the CD configuration-port arbiter.
package cd_cfg_pkg;

    localparam logic [3:0] CD_ADDR_VGA  = 4'b0100;
    localparam logic [3:0] CD_ADDR_UART = 4'b1000;
    localparam int         CD_W_VGA     = 3;
    localparam int         CD_W_UART    = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_ACK      = 3'd3,
        ST_GAP_WAIT = 3'd4
    } cd_state_e;

    typedef struct packed {
        logic       legal;
        logic [7:0] data;
    } cd_chk_t;

    // Unused data bits are forced to zero so CD never sees stray upper bits.
    function automatic cd_chk_t cd_check(input logic [3:0] addr, input logic [7:0] data);
        cd_chk_t r;
        r.legal = 1'b0;
        r.data  = 8'h00;
        case (addr)
            CD_ADDR_VGA: begin
                r.legal = 1'b1;
                r.data  = {5'b00000, data[CD_W_VGA-1:0]};
            end
            CD_ADDR_UART: begin
                r.legal = 1'b1;
                r.data  = {6'b000000, data[CD_W_UART-1:0]};
            end
            default: begin
                r.legal = 1'b0;
                r.data  = 8'h00;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cd_cfg_arbiter_rr_arbiter.sv
// Purely combinational round-robin selector: first active request strictly
// after the pointer wins, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_id_o,
    output logic          any_o
);

    // Scan N slots starting one past the pointer.
    always_comb begin
        logic [IW-1:0] idx;
        gnt_o    = '0;
        gnt_id_o = '0;
        any_o    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/cd_cfg_arbiter.sv
// Round-robin arbiter sharing the CD clock-divider config port between N requesters.
// Optional macro CD_CFG_TIMEOUT_EN adds an abort when c_ready never arrives.
module cd_cfg_arbiter
    import cd_cfg_pkg::*;
#(
    parameter int N        = 3,
    parameter int MIN_HOLD = 78,
    parameter int GAP      = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N-1:0]                         req_valid,
    input  logic [4*N-1:0]                       req_addr,
    input  logic [8*N-1:0]                       req_data,
    output logic [N-1:0]                         req_done,
    output logic [N-1:0]                         req_err,
    output logic                                 c_valid,
    output logic [3:0]                           c_addr,
    output logic [7:0]                           c_data,
    input  logic                                 c_ready,
    output logic                                 busy,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_id
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = $clog2(MIN_HOLD + 1);
    localparam int GW = $clog2(GAP + 1);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("cd_cfg_arbiter: N must be in 2..8");
    end
    if (MIN_HOLD < 1 || GAP < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("cd_cfg_arbiter: MIN_HOLD, GAP and TIMEOUT must be >= 1");
    end

    cd_state_e     state_q;
    logic [IW-1:0] rr_ptr_q, id_q, grant_id_q;
    logic [3:0]    addr_q, c_addr_q;
    logic [7:0]    data_q, c_data_q;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [GW-1:0] gap_cnt_q;
    logic          c_valid_q, busy_q;
    logic [N-1:0]  req_done_q, req_err_q;

    logic [N-1:0]  arb_gnt;
    logic [IW-1:0] arb_id;
    logic          arb_any;
    logic [3:0]    sel_addr;
    logic [7:0]    sel_data;
    cd_chk_t       chk;
    logic          hold_done, gap_last;

    rr_arbiter #(.N(N), .IW(IW)) u_rr (
        .req_i    (req_valid),
        .ptr_i    (rr_ptr_q),
        .gnt_o    (arb_gnt),
        .gnt_id_o (arb_id),
        .any_o    (arb_any)
    );

    // One-hot AND-OR mux of the granted requester's address and data.
    always_comb begin
        sel_addr = 4'h0;
        sel_data = 8'h00;
        for (int i = 0; i < N; i++) begin
            sel_addr = sel_addr | (req_addr[4*i +: 4] & {4{arb_gnt[i]}});
            sel_data = sel_data | (req_data[8*i +: 8] & {8{arb_gnt[i]}});
        end
    end

    // Legality check on latched values plus counter next-state and exit conditions.
    always_comb begin
        chk        = cd_check(addr_q, data_q);
        hold_cnt_d = (int'(hold_cnt_q) < MIN_HOLD) ? hold_cnt_q + HW'(1'b1) : hold_cnt_q;
        hold_done  = (int'(hold_cnt_q) >= MIN_HOLD - 1) && c_ready;
        gap_last   = int'(gap_cnt_q) >= GAP - 1;
    end

`ifdef CD_CFG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt_q;
    logic          to_expired;

    // Timeout fires on the TIMEOUT-th ISSUE cycle without completion.
    always_comb begin
        to_expired = int'(to_cnt_q) >= TIMEOUT - 1;
    end
`endif

    // Main FSM; every output is a register so CD sees glitch-free levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= IW'(N - 1);
            id_q       <= '0;
            grant_id_q <= '0;
            addr_q     <= 4'h0;
            data_q     <= 8'h00;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            c_valid_q  <= 1'b0;
            c_addr_q   <= 4'h0;
            c_data_q   <= 8'h00;
            busy_q     <= 1'b0;
            req_done_q <= '0;
            req_err_q  <= '0;
`ifdef CD_CFG_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            req_done_q <= '0;
            req_err_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        addr_q     <= sel_addr;
                        data_q     <= sel_data;
                        id_q       <= arb_id;
                        grant_id_q <= arb_id;
                        rr_ptr_q   <= arb_id;
                        busy_q     <= 1'b1;
                        state_q    <= ST_CHECK;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (chk.legal) begin
                        c_valid_q  <= 1'b1;
                        c_addr_q   <= addr_q;
                        c_data_q   <= chk.data;
                        hold_cnt_q <= '0;
`ifdef CD_CFG_TIMEOUT_EN
                        to_cnt_q   <= '0;
`endif
                        state_q    <= ST_ISSUE;
                    end else begin
                        req_err_q[id_q] <= 1'b1;
                        gap_cnt_q       <= '0;
                        state_q         <= ST_GAP_WAIT;
                    end
                end
                ST_ISSUE: begin
                    // Done is raised on the exit edge so it is visible during ACK.
                    if (hold_done) begin
                        c_valid_q        <= 1'b0;
                        c_addr_q         <= 4'h0;
                        c_data_q         <= 8'h00;
                        req_done_q[id_q] <= 1'b1;
                        state_q          <= ST_ACK;
                    end
`ifdef CD_CFG_TIMEOUT_EN
                    else if (to_expired) begin
                        c_valid_q       <= 1'b0;
                        c_addr_q        <= 4'h0;
                        c_data_q        <= 8'h00;
                        req_err_q[id_q] <= 1'b1;
                        gap_cnt_q       <= '0;
                        state_q         <= ST_GAP_WAIT;
                    end
`endif
                    else begin
                        hold_cnt_q <= hold_cnt_d;
`ifdef CD_CFG_TIMEOUT_EN
                        to_cnt_q   <= to_cnt_q + TW'(1'b1);
`endif
                    end
                end
                ST_ACK: begin
                    gap_cnt_q <= '0;
                    state_q   <= ST_GAP_WAIT;
                end
                ST_GAP_WAIT: begin
                    if (gap_last) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1'b1);
                    end
                end
                default: begin
                    c_valid_q <= 1'b0;
                    c_addr_q  <= 4'h0;
                    c_data_q  <= 8'h00;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_done = req_done_q;
    assign req_err  = req_err_q;
    assign c_valid  = c_valid_q;
    assign c_addr   = c_addr_q;
    assign c_data   = c_data_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule
